// File: rtl/dmem_bus_pkg.sv
// Shared types for the data-memory responder: FSM states, response bundle and
// the width of the wait-state counter.
package dmem_bus_pkg;

    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

endpackage

// File: rtl/sram_bw.sv
// Single-port word array with byte-masked synchronous write (active-low lane
// enables) and synchronous read. Contents are never reset.
module sram_bw #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clock,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    be_l_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clock) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (!be_l_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: accepts one request at a time, waits
// WAIT_STATES cycles, performs the access on sram_bw and holds the response.
module dmem_responder
    import dmem_bus_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be_L,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_l_q;
    logic [WAIT_W-1:0] cnt_q;
    logic              err_q;

    logic [ADDR_W-3:0] word_idx;
    logic              addr_err;
    logic              op_now;
    logic [31:0]       sram_rdata;
    rsp_t              rsp;

    assign word_idx = addr_q[ADDR_W-1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || (32'(word_idx) >= DEPTH);
    assign op_now   = (state_q == StAccess) && (cnt_q == '0);

    // Erroneous requests never touch the array.
    sram_bw #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clock   (clock),
        .en_i    (op_now && !addr_err),
        .we_i    (we_q),
        .addr_i  (word_idx[AW-1:0]),
        .wdata_i (wdata_q),
        .be_l_i  (be_l_q),
        .rdata_o (sram_rdata)
    );

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_l_q  <= 4'hF;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_l_q  <= req_be_L;
                        cnt_q   <= WAIT_W'(WAIT_STATES);
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - WAIT_W'(1);
                    end else begin
                        err_q   <= addr_err;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        err_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read data stays valid in the SRAM output register until the next read.
    always_comb begin
        rsp = '0;
        if (state_q == StResp) begin
            rsp.err = err_q;
            if (!we_q && !err_q) begin
                rsp.rdata = sram_rdata;
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rsp.rdata;
    assign rsp_err   = rsp.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: two instances (0 and 3
// wait states) checked against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 1000;

    logic        clock = 1'b0;
    logic        reset_L   [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [11:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be_L  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks = 0;
    int passed = 0;
    logic [31:0] mdl [2][1024];

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(12), .WAIT_STATES(0)) u_dut0 (
        .clock(clock), .reset_L(reset_L[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be_L(req_be_L[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(12), .WAIT_STATES(3)) u_dut1 (
        .clock(clock), .reset_L(reset_L[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be_L(req_be_L[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Reference: misaligned or beyond DEPTH is an error; writes merge enabled bytes.
    task automatic model_apply(input int d, input logic we, input logic [11:0] a,
                               input logic [31:0] wd, input logic [3:0] be,
                               output logic [31:0] erd, output logic eer);
        int w;
        w   = int'(a) / 4;
        eer = (int'(a) % 4 != 0) || (w >= DEPTH);
        erd = 32'h0;
        if (!eer) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (!be[i]) mdl[d][w][8*i +: 8] = wd[8*i +: 8];
                end
            end else begin
                erd = mdl[d][w];
            end
        end
    endtask

    task automatic xact(input int d, input logic we, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input int hold,
                        input string nm);
        logic [31:0] erd, rd0;
        logic        eer, er0;
        int          n, lat;
        bit          stable;
        model_apply(d, we, a, wd, be, erd, eer);
        @(negedge clock);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a;
        req_wdata[d] = wd; req_be_L[d] = be; rsp_ready[d] = 1'b0;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready[d]) begin
            checks++;
            $display("FAIL %s dut%0d accept timeout: req_ready=%b required 1", nm, d, req_ready[d]);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        // Garbage on the request bus must be ignored while busy.
        req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_addr[d] = 12'($urandom);
        req_wdata[d] = $urandom; req_be_L[d] = 4'($urandom);
        lat = 0; stable = 1'b1;
        @(negedge clock);
        while (!rsp_valid[d] && lat < 100) begin
            if (req_ready[d]) stable = 1'b0;
            @(negedge clock);
            lat++;
        end
        checks++;
        if (lat !== 1 + ws_of(d))
            $display("FAIL %s dut%0d latency: got %0d required %0d", nm, d, lat, 1 + ws_of(d));
        else passed++;
        rd0 = rsp_rdata[d]; er0 = rsp_err[d];
        repeat (hold) begin
            @(negedge clock);
            if (!rsp_valid[d] || rsp_rdata[d] !== rd0 || rsp_err[d] !== er0 || req_ready[d])
                stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1)
            $display("FAIL %s dut%0d busy/hold stability: got %b required 1", nm, d, stable);
        else passed++;
        checks++;
        if (rd0 !== erd) $display("FAIL %s dut%0d rdata: got %h required %h", nm, d, rd0, erd);
        else passed++;
        checks++;
        if (er0 !== eer) $display("FAIL %s dut%0d err: got %b required %b", nm, d, er0, eer);
        else passed++;
        rsp_ready[d] = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready[d] = 1'b0;
        checks++;
        if (rsp_valid[d] !== 1'b0 || rsp_err[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 ||
            req_ready[d] !== 1'b1)
            $display("FAIL %s dut%0d after completion: valid=%b err=%b rdata=%h ready=%b required 0 0 0 1",
                     nm, d, rsp_valid[d], rsp_err[d], rsp_rdata[d], req_ready[d]);
        else passed++;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            reset_L[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_be_L[d] = 4'hF; rsp_ready[d] = 1'b0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 ||
                rsp_err[d] !== 1'b0)
                $display("FAIL reset dut%0d: ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
            else passed++;
        end
        @(negedge clock);
        reset_L[0] = 1'b1; reset_L[1] = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 32; w++) xact(d, 1'b1, 12'(w * 4), $urandom, 4'h0, 0, "init");
    endtask

    task automatic test_basic();
        xact(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'b0000, 0, "basic_wr");
        xact(0, 1'b0, 12'h010, 32'h0, 4'b0000, 0, "basic_rd");
    endtask

    task automatic test_partial();
        xact(0, 1'b1, 12'h020, 32'h11223344, 4'b0000, 0, "part_full");
        xact(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'b1010, 1, "part_mask");
        xact(0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'b1111, 0, "part_none");
        xact(0, 1'b0, 12'h020, 32'h0, 4'b0101, 0, "part_rd");
    endtask

    task automatic test_error();
        xact(0, 1'b0, 12'h013, 32'h0, 4'h0, 0, "err_misalign");
        xact(0, 1'b0, 12'hFFC, 32'h0, 4'h0, 0, "err_range");
        xact(0, 1'b1, 12'h011, 32'h01020304, 4'h0, 0, "err_wr_misalign");
        xact(0, 1'b1, 12'hFA0, 32'h01020304, 4'h0, 0, "err_wr_1000");
        xact(0, 1'b0, 12'h010, 32'h0, 4'h0, 0, "err_unchanged");
        xact(0, 1'b1, 12'hF9C, 32'hCAFEF00D, 4'h0, 0, "edge_wr_999");
        xact(0, 1'b0, 12'hF9C, 32'h0, 4'h0, 0, "edge_rd_999");
    endtask

    task automatic test_stall();
        xact(1, 1'b1, 12'h010, 32'h0BADC0DE, 4'h0, 0, "stall_wr");
        xact(1, 1'b0, 12'h010, 32'h0, 4'h0, 5, "stall_rd");
    endtask

    task automatic test_reset_mid();
        xact(1, 1'b1, 12'h040, 32'h12345678, 4'h0, 0, "rmid_pre");
        @(negedge clock);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 12'h040;
        req_wdata[1] = 32'h55; req_be_L[1] = 4'h0;
        @(posedge clock);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (req_ready[1] !== 1'b0)
            $display("FAIL rmid busy before reset: req_ready=%b required 0", req_ready[1]);
        else passed++;
        reset_L[1] = 1'b0;
        #1;
        checks++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 ||
            rsp_err[1] !== 1'b0)
            $display("FAIL rmid reset outputs: ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                     req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]);
        else passed++;
        @(negedge clock);
        reset_L[1] = 1'b1;
        xact(1, 1'b0, 12'h040, 32'h0, 4'h0, 0, "rmid_rd");
    endtask

    task automatic test_random(input int d);
        logic [11:0] a;
        int          r;
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 12'($urandom_range(0, 31) * 4);
            else if (r < 9)  a = 12'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            else             a = 12'($urandom_range(1000, 1023) * 4);
            xact(d, 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 2)), "rand");
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic        we_v [4];
        logic [11:0] a_v  [4];
        logic [31:0] wd_v [4];
        logic [3:0]  be_v [4];
        logic [31:0] erd  [4];
        logic        eer  [4];
        int          acc  [4];
        int          k, got, cyc;
        bit          overlap, accepted;
        we_v = '{1'b1, 1'b0, 1'b1, 1'b0};
        a_v  = '{12'h014, 12'h014, 12'h018, 12'h018};
        wd_v = '{$urandom, $urandom, $urandom, $urandom};
        be_v = '{4'h0, 4'h0, 4'($urandom), 4'h0};
        for (int i = 0; i < 4; i++) model_apply(d, we_v[i], a_v[i], wd_v[i], be_v[i], erd[i], eer[i]);
        @(negedge clock);
        rsp_ready[d] = 1'b1;
        k = 0; got = 0; cyc = 0; overlap = 1'b0;
        req_valid[d] = 1'b1; req_we[d] = we_v[0]; req_addr[d] = a_v[0];
        req_wdata[d] = wd_v[0]; req_be_L[d] = be_v[0];
        while ((k < 4 || got < 4) && cyc < 200) begin
            accepted = req_valid[d] && req_ready[d];
            if (accepted) acc[k] = cyc;
            if (req_ready[d] && rsp_valid[d]) overlap = 1'b1;
            if (rsp_valid[d] && got < 4) begin
                checks++;
                if (rsp_rdata[d] !== erd[got] || rsp_err[d] !== eer[got])
                    $display("FAIL b2b dut%0d rsp%0d: got %h/%b required %h/%b",
                             d, got, rsp_rdata[d], rsp_err[d], erd[got], eer[got]);
                else passed++;
                got++;
            end
            @(posedge clock);
            #1;
            if (accepted) begin
                k++;
                if (k < 4) begin
                    req_we[d] = we_v[k]; req_addr[d] = a_v[k];
                    req_wdata[d] = wd_v[k]; req_be_L[d] = be_v[k];
                end else begin
                    req_valid[d] = 1'b0;
                end
            end
            @(negedge clock);
            cyc++;
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b0;
        checks++;
        if (k != 4 || got != 4)
            $display("FAIL b2b dut%0d progress: accepts=%0d responses=%0d required 4 4", d, k, got);
        else passed++;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (k == 4 && acc[i] - acc[i-1] == 3 + ws_of(d)) passed++;
            else $display("FAIL b2b dut%0d spacing%0d: got %0d required %0d",
                          d, i, acc[i] - acc[i-1], 3 + ws_of(d));
        end
        checks++;
        if (overlap !== 1'b0)
            $display("FAIL b2b dut%0d ready during response: got %b required 0", d, overlap);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_error();
        test_stall();
        test_reset_mid();
        test_random(0);
        test_random(1);
        test_back_to_back(0);
        test_back_to_back(1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Handshaked data-memory responder: the memory side of the load/store bus that the core's load/store unit drives. It accepts one word-granular read or write request at a time over a valid/ready channel, models configurable wait states, commits byte-masked writes into an internal word array, and returns read data or an error on a separate valid/ready response channel. It sits between the LSU-side bus initiator and the data storage, replacing the zero-latency combinational data memory.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words in the array
- ADDR_W, 12, byte-address width; 4*DEPTH <= 2**ADDR_W is required
- WAIT_STATES, 0, extra ACCESS cycles per request (0..15)

Ports:
- clock  in  1  single clock, rising edge
- reset_L  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  write data, byte lanes aligned to word
- req_be_L  in  4  active-low byte write enables (bit i = byte lane i)
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_err  out  1  request was misaligned or out of range

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On edge with req_valid&&req_ready: latch we/addr/wdata/be_L, load wait counter with WAIT_STATES, go ACCESS.
- ACCESS: req_ready=0. While counter != 0: decrement, stay. At counter==0 edge: perform operation, go RESP.
- Operation: err = (addr[1:0] != 0) || (addr[ADDR_W-1:2] >= DEPTH). If err: no array write, rsp_rdata=0, rsp_err=1. Else write: bytes with be_L[i]==0 updated, rsp_rdata=0; be_L=4'b1111 writes nothing, still OK response. Else read: full word regardless of be_L into rsp_rdata.
- RESP: rsp_valid=1, outputs held stable. On edge with rsp_ready: rsp_valid=0, rsp_rdata=0, rsp_err=0, go IDLE.
- One outstanding request; no accept in the same cycle a response completes.
- Array contents are not reset; uninitialised reads return whatever the array holds (X in simulation).

## Timing
- Reset (reset_L low, asynchronous): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. A write not yet committed is dropped; a committed write persists.
- Accept at edge E: ACCESS during cycles E..E+WAIT_STATES; operation at edge E+1+WAIT_STATES; rsp_valid high from that edge.
- WAIT_STATES=0: accept edge 0, rsp_valid after edge 1, earliest response completion edge 2, req_ready after edge 2, next accept edge 3. Peak throughput one request per 3+WAIT_STATES cycles.
- Read-after-write to same address returns new data (write commits before the later read's operation edge).
- rsp_ready held low: rsp_valid, rsp_rdata, rsp_err stable indefinitely; req_ready stays 0.
- req_* inputs ignored outside IDLE; only latched values used.

## Structure
- Package dmem_bus_pkg: state enum (IDLE, ACCESS, RESP), response-struct typedef (rdata, err), WAIT_W=4 constant.
- Sub-module sram_bw: DEPTH x 32 array, one port, synchronous byte-masked write with active-low enables, synchronous read; instantiated once. FSM, counter, and range check stay in dmem_responder.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to 0x010 be_L=4'b0000, then read 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid one cycle after each accept edge.
- Partial write: 0x11223344 full, then 0xAABBCCDD with be_L=4'b1010 to 0x020; read -> 0x11BB33DD.
- Error: read 0x013 (misaligned) and read 0xFFC with DEPTH=1000 -> rsp_err=1, rsp_rdata=0; array at 0x010 unchanged.
- WAIT_STATES=3 with rsp_ready held low 5 cycles: rsp_valid rises 4 cycles after accept, data stable until rsp_ready, req_ready low throughout.
- Reset mid-ACCESS (WAIT_STATES=3, write 0x55 to 0x040, reset_L low in second ACCESS cycle): outputs go to reset values immediately; subsequent read of 0x040 returns prior contents.
- Back-to-back: req_valid held high with 4 requests, rsp_ready=1 -> one accept per 3 cycles, responses in order, no accept on a response-completion edge.
